// File: rtl/mux2_rr_arbiter.sv
// Two-requester packet arbiter driving a 2:1 mux select, with a registered valid/ready output stage.
// Define MUX2_ARB_STATS_EN to add per-requester packet counters and a truncation counter.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_last,
  output logic             in2_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             trunc_err
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [15:0]      pkt_cnt1,
  output logic [15:0]      pkt_cnt2,
  output logic [7:0]       trunc_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT1 = 2'd1;
  localparam logic [1:0] GNT2 = 2'd2;

  logic [1:0]       state;
  logic             ptr;        // 0: in1 wins a tie, 1: in2 wins a tie
  logic [7:0]       beat_cnt;
  logic             stage_free;
  logic             xfer1;
  logic             xfer2;
  logic             xfer;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_last;
  logic             at_max;
  logic             forced;
  logic             pkt_end;

  assign stage_free = !out_valid || out_ready;
  assign in1_ready  = (state == GNT1) && stage_free;
  assign in2_ready  = (state == GNT2) && stage_free;
  assign xfer1      = in1_valid && in1_ready;
  assign xfer2      = in2_valid && in2_ready;
  assign xfer       = xfer1 || xfer2;
  assign xfer_data  = xfer2 ? in2_data : in1_data;
  assign xfer_last  = xfer2 ? in2_last : in1_last;
  assign at_max     = (beat_cnt == 8'(MAX_BEATS - 1));
  assign forced     = xfer && !xfer_last && at_max;
  assign pkt_end    = xfer && (xfer_last || at_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in1_valid && (!in2_valid || !ptr)) begin
            state <= GNT1;
            sel   <= 1'b0;
          end else if (in2_valid) begin
            state <= GNT2;
            sel   <= 1'b1;
          end
        end
        GNT1, GNT2: begin
          // The requester just served loses the next tie.
          if (pkt_end) begin
            state <= IDLE;
            ptr   <= (state == GNT1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pkt_end) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= forced;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= xfer_data;
        out_last  <= xfer_last || at_max;
      end else if (stage_free) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX2_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt1  <= '0;
      pkt_cnt2  <= '0;
      trunc_cnt <= '0;
    end else begin
      if (pkt_end && xfer1) pkt_cnt1 <= pkt_cnt1 + 16'd1;
      if (pkt_end && xfer2) pkt_cnt2 <= pkt_cnt2 + 16'd1;
      if (trunc_err && (trunc_cnt != 8'hFF)) trunc_cnt <= trunc_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (MAX_BEATS=4): reset, single packet, round-robin tie,
// backpressure and truncation, with queue-fed producers and an output beat capture.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in1_valid, in1_last, in1_ready;
  logic [7:0] in1_data;
  logic       in2_valid, in2_last, in2_ready;
  logic [7:0] in2_data;
  logic       sel, out_valid, out_last, out_ready, trunc_err;
  logic [7:0] out_data;
`ifdef MUX2_ARB_STATS_EN
  logic [15:0] pkt_cnt1, pkt_cnt2;
  logic [7:0]  trunc_cnt;
`endif

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_last(in2_last), .in2_ready(in2_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .trunc_err(trunc_err)
`ifdef MUX2_ARB_STATS_EN
    , .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2), .trunc_cnt(trunc_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       sel;
    logic       trunc;
    int         cyc;
  } beat_t;

  logic [8:0] q1[$];
  logic [8:0] q2[$];
  beat_t      cap[$];
  int         cyc = 0;
  int         trunc_seen = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc++;

  // Producers: {last, data} words; a beat retires when it was accepted at the previous edge.
  initial begin
    logic acc1, acc2;
    in1_valid = 0; in1_data = 0; in1_last = 0;
    in2_valid = 0; in2_data = 0; in2_last = 0;
    forever begin
      @(negedge clk);
      acc1 = in1_valid && in1_ready;
      acc2 = in2_valid && in2_ready;
      @(posedge clk);
      #2;
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      if (acc2 && q2.size() > 0) void'(q2.pop_front());
      in1_valid = (q1.size() > 0);
      in1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      in1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
      in2_valid = (q2.size() > 0);
      in2_data  = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
      in2_last  = (q2.size() > 0) ? q2[0][8] : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      cap.push_back('{data: out_data, last: out_last, sel: sel, trunc: trunc_err, cyc: cyc});
    if (!rst && trunc_err) trunc_seen++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_caps(input string tag, input int n);
    int budget = 200;
    while (cap.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    check_val({tag, "_count"}, cap.size(), n);
  endtask

  task automatic expect_beat(input string tag, input int i, input logic [7:0] d,
                             input logic l, input logic s);
    if (i < cap.size()) begin
      check_val({tag, "_data"}, cap[i].data, d);
      check_val({tag, "_last"}, cap[i].last, l);
      check_val({tag, "_sel"},  cap[i].sel,  s);
    end else begin
      check_val({tag, "_missing"}, cap.size(), i + 1);
    end
  endtask

  task automatic expect_gap(input string tag, input int i, input int gap);
    if (i + 1 < cap.size()) check_val(tag, cap[i+1].cyc - cap[i].cyc, gap);
    else check_val({tag, "_missing"}, cap.size(), i + 2);
  endtask

  initial begin
    int t0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data",  out_data, 0);
    check_val("rst_out_last",  out_last, 0);
    check_val("rst_sel",       sel, 0);
    check_val("rst_trunc",     trunc_err, 0);
    check_val("rst_ready1",    in1_ready, 0);
    check_val("rst_ready2",    in2_ready, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Reset mid-packet from in2
    cap.delete();
    q2.push_back({1'b0, 8'h50}); q2.push_back({1'b0, 8'h51}); q2.push_back({1'b1, 8'h52});
    wait_caps("midrst", 1);
    check_val("midrst_sel_before", sel, 1);
    rst = 1'b1;
    q2.delete();
    @(negedge clk);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_sel",       sel, 0);
    check_val("midrst_out_last",  out_last, 0);
    check_val("midrst_ready2",    in2_ready, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (2) tick();

    // Round-robin tie, in1 must win first after reset
    cap.delete();
    q1.push_back({1'b0, 8'h10}); q1.push_back({1'b1, 8'h11});
    q1.push_back({1'b0, 8'h10}); q1.push_back({1'b1, 8'h11});
    q2.push_back({1'b0, 8'h20}); q2.push_back({1'b1, 8'h21});
    q2.push_back({1'b0, 8'h20}); q2.push_back({1'b1, 8'h21});
    wait_caps("rr", 8);
    expect_beat("rr0", 0, 8'h10, 0, 0);
    expect_beat("rr1", 1, 8'h11, 1, 0);
    expect_beat("rr2", 2, 8'h20, 0, 1);
    expect_beat("rr3", 3, 8'h21, 1, 1);
    expect_beat("rr4", 4, 8'h10, 0, 0);
    expect_beat("rr5", 5, 8'h11, 1, 0);
    expect_beat("rr6", 6, 8'h20, 0, 1);
    expect_beat("rr7", 7, 8'h21, 1, 1);
    expect_gap("rr_gap_in_pkt", 0, 1);
    expect_gap("rr_gap_between", 1, 2);
    repeat (3) tick();

    // Single requester, three beats
    cap.delete();
    t0 = cyc;
    q1.push_back({1'b0, 8'hAA}); q1.push_back({1'b0, 8'hBB}); q1.push_back({1'b1, 8'hCC});
    wait_caps("single", 3);
    expect_beat("single0", 0, 8'hAA, 0, 0);
    expect_beat("single1", 1, 8'hBB, 0, 0);
    expect_beat("single2", 2, 8'hCC, 1, 0);
    if (cap.size() > 0) check_val("single_latency", cap[0].cyc - t0, 2);
    expect_gap("single_gap01", 0, 1);
    expect_gap("single_gap12", 1, 1);
    repeat (3) tick();

    // Truncation: in2 sends 6 beats with no last, then a closing beat
    cap.delete();
    for (int i = 0; i < 6; i++) q2.push_back({1'b0, 8'h30 + 8'(i)});
    q2.push_back({1'b1, 8'h36});
    wait_caps("trunc", 7);
    expect_beat("trunc0", 0, 8'h30, 0, 1);
    expect_beat("trunc3", 3, 8'h33, 1, 1);
    expect_beat("trunc4", 4, 8'h34, 0, 1);
    expect_beat("trunc6", 6, 8'h36, 1, 1);
    if (cap.size() > 3) check_val("trunc_pulse_b4", cap[3].trunc, 1);
    if (cap.size() > 6) check_val("trunc_pulse_b7", cap[6].trunc, 0);
    expect_gap("trunc_rearb_gap", 3, 2);
    repeat (3) tick();
    check_val("trunc_pulses", trunc_seen, 1);

    // Backpressure mid-packet
    cap.delete();
    q1.push_back({1'b0, 8'h40}); q1.push_back({1'b0, 8'h41}); q1.push_back({1'b1, 8'h42});
    wait_caps("bp_first", 1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("bp_frozen_data",  out_data, 8'h41);
      check_val("bp_frozen_valid", out_valid, 1);
      check_val("bp_ready1",       in1_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    wait_caps("bp", 3);
    repeat (4) tick();
    check_val("bp_no_dup", cap.size(), 3);
    expect_beat("bp0", 0, 8'h40, 0, 0);
    expect_beat("bp1", 1, 8'h41, 0, 0);
    expect_beat("bp2", 2, 8'h42, 1, 0);

`ifdef MUX2_ARB_STATS_EN
    check_val("stats_pkt1",  pkt_cnt1, 4);
    check_val("stats_pkt2",  pkt_cnt2, 4);
    check_val("stats_trunc", trunc_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
